// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multicycle MIPS control unit and datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that stall on the memory handshake.
  function automatic logic is_wait(logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; expire flags the last
// allowed cycle. TIMEOUT=0 removes the counter so waits never expire.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_none
      assign expire = 1'b0;
    end else begin : g_cnt
      localparam int W = $clog2(TIMEOUT + 1);
      logic [W-1:0] cnt;

      assign expire = waiting & ~mem_ready &
                      (cnt == W'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (reset || !waiting || mem_ready || expire)
          cnt <= '0;
        else
          cnt <= cnt + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/mc_maindec_fsm.sv
// Multicycle MIPS main control FSM with memory handshake and bus timeout.
// Define MCDEC_BNE_EN to decode bne (op 000101) through the BRANCH state.
module mc_maindec_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               pcen,
  output logic               illegal_op,
  output logic               bus_err,
  output logic [STATE_W-1:0] state_o
);

  logic [3:0] state, next;
  logic expire, waiting, taken;
  logic pcwrite, branch;
  logic ir_raw, mw_raw, rw_raw;
  logic op_r, op_lw, op_sw, op_beq, op_bne;
  logic op_addi, op_j, op_br, bad_op;

  assign op_r    = op == OP_W'(OP_RTYPE);
  assign op_lw   = op == OP_W'(OP_LW);
  assign op_sw   = op == OP_W'(OP_SW);
  assign op_beq  = op == OP_W'(OP_BEQ);
  assign op_addi = op == OP_W'(OP_ADDI);
  assign op_j    = op == OP_W'(OP_J);

`ifdef MCDEC_BNE_EN
  logic bne_q;

  assign op_bne = op == OP_W'(OP_BNE);
  assign taken  = zero ^ bne_q;

  always_ff @(posedge clk) begin
    if (reset)
      bne_q <= 1'b0;
    else if (state == S_DECODE)
      bne_q <= op_bne;
    else if (state == S_BRANCH)
      bne_q <= 1'b0;
  end
`else
  assign op_bne = 1'b0;
  assign taken  = zero;
`endif

  assign op_br  = op_beq | op_bne;
  assign bad_op = ~(op_r | op_lw | op_sw | op_br |
                    op_addi | op_j);

  assign waiting = is_wait(state);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .expire   (expire)
  );

  always_comb begin
    next = state;
    unique case (state)
      S_FETCH: begin
        if (mem_ready)   next = S_DECODE;
        else if (expire) next = S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          op_lw, op_sw: next = S_MEMADR;
          op_r:         next = S_EXECUTE;
          op_br:        next = S_BRANCH;
          op_addi:      next = S_ADDIEX;
          op_j:         next = S_JUMP;
          default:      next = S_FETCH;
        endcase
      end
      S_MEMADR:  next = op_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)   next = S_MEMWB;
        else if (expire) next = S_FETCH;
      end
      S_MEMWB:   next = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || expire) next = S_FETCH;
      end
      S_EXECUTE: next = S_ALUWB;
      S_ALUWB:   next = S_FETCH;
      S_BRANCH:  next = S_FETCH;
      S_ADDIEX:  next = S_ADDIWB;
      S_ADDIWB:  next = S_FETCH;
      S_JUMP:    next = S_FETCH;
      default:   next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    iord     = 1'b0;
    mw_raw   = 1'b0;
    ir_raw   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    rw_raw   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RB;
    pcsrc    = PC_ALU;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    unique case (state)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        ir_raw  = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:  alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw_raw   = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mw_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        rw_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB:  rw_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // A timed-out write must not commit; reset kills every strobe.
  assign irwrite    = ~reset & ir_raw;
  assign memwrite   = ~reset & mw_raw & ~expire;
  assign regwrite   = ~reset & rw_raw;
  assign pcen       = ~reset & (pcwrite | (branch & taken));
  assign illegal_op = ~reset & (state == S_DECODE) & bad_op;
  assign bus_err    = ~reset & expire;
  assign state_o    = STATE_W'(state);

endmodule
